// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types, defaults and saturating audio arithmetic for the echo engine
package echo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 13;
    localparam int GAIN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_MAC,
        ST_WRITE
    } echo_state_e;

    // Signed sample times unsigned gain fraction, floored by the gain width.
    function automatic logic signed [31:0] gain_mul(input logic signed [31:0] d,
                                                    input logic        [31:0] g,
                                                    input int                 gw);
        logic signed [63:0] p;
        p = 64'(d) * $signed({32'd0, g});
        return 32'(p >>> gw);
    endfunction

    // Add and clamp to the signed range of a w-bit sample.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 w);
        logic signed [33:0] s;
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        s  = 34'(a) + 34'(b);
        hi = (34'sd1 <<< (w - 1)) - 34'sd1;
        lo = -hi - 34'sd1;
        if (s > hi) begin
            return 32'(hi);
        end
        if (s < lo) begin
            return 32'(lo);
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - simple dual-port sample buffer with one-cycle registered read
module echo_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_delay_line.sv
// rtl/echo_delay_line.sv - echo engine: circular buffer, feedback and wet/dry mix, 3-cycle latency
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [ADDR_W-1:0] delay_num,
    input  logic        [GAIN_W-1:0] fb_gain,
    input  logic        [GAIN_W-1:0] mix_gain,
    input  logic                     bypass,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    echo_state_e              state_q;
    logic signed [DATA_W-1:0] in_q;
    logic        [GAIN_W-1:0] fb_q;
    logic        [GAIN_W-1:0] mix_q;
    logic                     bypass_q;
    logic        [ADDR_W-1:0] rd_addr_q;
    logic                     use_d_q;
    logic        [ADDR_W-1:0] wr_ptr_q;
    logic        [ADDR_W-1:0] fill_q;
    logic signed [DATA_W-1:0] wdata_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     busy_q;
    logic                     overrun_q;

    logic        [DATA_W-1:0] ram_rdata;
    logic signed [DATA_W-1:0] d_s;
    logic signed [DATA_W-1:0] wet_d;
    logic signed [DATA_W-1:0] fbv_d;

    // Write enable follows the state directly so an async reset kills a pending write at once.
    echo_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (state_q == ST_WRITE),
        .waddr(wr_ptr_q),
        .wdata(wdata_q),
        .raddr(rd_addr_q),
        .rdata(ram_rdata)
    );

    assign d_s   = use_d_q ? $signed(ram_rdata) : '0;
    assign wet_d = DATA_W'(sat_add(32'(in_q), gain_mul(32'(d_s), 32'(mix_q), GAIN_W), DATA_W));
    assign fbv_d = DATA_W'(sat_add(32'(in_q), gain_mul(32'(d_s), 32'(fb_q), GAIN_W), DATA_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_q        <= '0;
            fb_q        <= '0;
            mix_q       <= '0;
            bypass_q    <= 1'b0;
            rd_addr_q   <= '0;
            use_d_q     <= 1'b0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_q      <= in_data;
                        fb_q      <= fb_gain;
                        mix_q     <= mix_gain;
                        bypass_q  <= bypass;
                        rd_addr_q <= wr_ptr_q - delay_num;
                        // Unwritten or stale locations read back as silence.
                        use_d_q   <= (delay_num != '0) && (fill_q >= delay_num);
                        busy_q    <= 1'b1;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_MAC;
                end
                ST_MAC: begin
                    out_data_q  <= bypass_q ? in_q : wet_d;
                    wdata_q     <= bypass_q ? in_q : fbv_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + ADDR_W'(1);
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay_line.sv
// tb/tb_echo_delay_line.sv - randomized and directed checks of echo_delay_line against a history model
module tb_echo_delay_line;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int GW = 8;
    localparam int NO_OVR = 1 << 30;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic        [AW-1:0] delay_num = '0;
    logic        [GW-1:0] fb_gain = '0;
    logic        [GW-1:0] mix_gain = '0;
    logic                 bypass = 1'b0;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 overrun;

    echo_delay_line #(.DATA_W(DW), .ADDR_W(AW), .GAIN_W(GW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .delay_num(delay_num), .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hist[$];
    int exp_data[$];
    int exp_cyc[$];
    int log_out[$];
    int ovr_from = NO_OVR;
    int last_out = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int fdiv(input int p);
        int q;
        q = p / (1 << GW);
        if (p < 0 && (p % (1 << GW)) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int s);
        int hi;
        hi = (1 << (DW - 1)) - 1;
        if (s > hi) return hi;
        if (s < -hi - 1) return -hi - 1;
        return s;
    endfunction

    // Echo source is the sample written 'dly' accepted samples ago, silence if none yet.
    task automatic model_push(input int data, input int dly, input int fb, input int mix, input bit byp);
        int n;
        int d;
        n = hist.size();
        d = (dly != 0 && n >= dly) ? hist[n - dly] : 0;
        exp_data.push_back(byp ? data : sat(data + fdiv(d * mix)));
        exp_cyc.push_back(cyc + 3);
        hist.push_back(byp ? data : sat(data + fdiv(d * fb)));
    endtask

    task automatic send(input int data, input int dly, input int fb, input int mix,
                        input bit byp, input int gap, input bit drop);
        @(negedge clk);
        in_data   = DW'(data);
        delay_num = AW'(dly);
        fb_gain   = GW'(fb);
        mix_gain  = GW'(mix);
        bypass    = byp;
        in_valid  = 1'b1;
        model_push(data, dly, fb, mix, byp);
        @(negedge clk);
        in_valid = 1'b0;
        if (drop) begin
            @(negedge clk);
            in_data  = DW'(12345);
            in_valid = 1'b1;
            if (ovr_from > cyc + 1) ovr_from = cyc + 1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap - 4) @(negedge clk);
        end else begin
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic clear_model();
        hist.delete();
        exp_data.delete();
        exp_cyc.delete();
        ovr_from = NO_OVR;
        last_out = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        #1;
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        clear_model();
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            chk("overrun", overrun, int'(cyc >= ovr_from));
            if (exp_cyc.size() > 0 && cyc > exp_cyc[0]) begin
                chk("out_valid_missing", 0, 1);
                void'(exp_cyc.pop_front());
                void'(exp_data.pop_front());
            end
            chk("busy", busy, int'(exp_cyc.size() > 0 && cyc >= exp_cyc[0] - 2));
            if (out_valid) begin
                if (exp_cyc.size() == 0) begin
                    chk("out_valid_spurious", 1, 0);
                end else begin
                    chk("out_latency", cyc, exp_cyc[0]);
                    chk("out_data", out_data, exp_data[0]);
                    void'(exp_cyc.pop_front());
                    void'(exp_data.pop_front());
                end
                last_out = out_data;
                log_out.push_back(out_data);
            end else begin
                chk("out_hold", out_data, last_out);
            end
        end else begin
            chk("in_reset_out_valid", out_valid, 0);
            chk("in_reset_busy", busy, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        int ins[$];
        int v;
        repeat (3) @(negedge clk);
        check_zero_outputs("por");
        reset_n = 1'b1;

        // Impulse through a 4-sample delay.
        b = log_out.size();
        for (int i = 0; i < 8; i++) send((i == 0) ? 1000 : 0, 4, 0, 255, 1'b0, 8, 1'b0);
        repeat (4) @(negedge clk);
        chk("impulse_count", log_out.size() - b, 8);
        if (log_out.size() - b == 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("impulse_s%0d", i), log_out[b + i], (i == 0) ? 1000 : ((i == 4) ? 996 : 0));
        end

        // Feedback decay: repeats halve every two samples.
        do_reset();
        b = log_out.size();
        for (int i = 0; i < 8; i++) send((i == 0) ? 1024 : 0, 2, 128, 255, 1'b0, 4, 1'b0);
        repeat (4) @(negedge clk);
        chk("decay_count", log_out.size() - b, 8);
        if (log_out.size() - b == 8) begin
            chk("decay_s0", log_out[b], 1024);
            chk("decay_s2", log_out[b + 2], 1020);
            chk("decay_s4", log_out[b + 4], 510);
            chk("decay_s6", log_out[b + 6], 255);
            chk("decay_s3", log_out[b + 3], 0);
        end

        // Saturation at both rails.
        for (int pol = 0; pol < 2; pol++) begin
            do_reset();
            b = log_out.size();
            for (int i = 0; i < 6; i++) send(pol ? -30000 : 30000, 1, 255, 255, 1'b0, 5, 1'b0);
            repeat (4) @(negedge clk);
            chk("sat_count", log_out.size() - b, 6);
            if (log_out.size() - b == 6) begin
                for (int i = 1; i < 6; i++) chk($sformatf("sat%0d_s%0d", pol, i), log_out[b + i], pol ? -32768 : 32767);
            end
        end

        // Fill gating: early samples stay dry, then a longer delay, then delay 0.
        do_reset();
        b = log_out.size();
        ins.delete();
        for (int i = 0; i < 14; i++) begin
            v = int'($urandom_range(0, 20000)) - 10000;
            ins.push_back(v);
            send(v, 10, 64, 200, 1'b0, 4, 1'b0);
        end
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 20000)) - 10000, 15, 64, 200, 1'b0, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 20000)) - 10000;
            ins.push_back(v);
            send(v, 0, 255, 255, 1'b0, 4, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("fill_count", log_out.size() - b, 28);
        if (log_out.size() - b == 28) begin
            for (int i = 0; i < 10; i++) chk($sformatf("fill_dry_s%0d", i), log_out[b + i], ins[i]);
            for (int i = 0; i < 4; i++) chk($sformatf("delay0_s%0d", i), log_out[b + 24 + i], ins[14 + i]);
        end

        // Long echo across pointer wrap, then bypass.
        do_reset();
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 40000)) - 20000, 15, 100, 200, 1'b0, 4, 1'b0);
        b = log_out.size();
        ins.delete();
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            ins.push_back(v);
            send(v, 3, 255, 255, 1'b1, 4, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("bypass_count", log_out.size() - b, 6);
        if (log_out.size() - b == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("bypass_s%0d", i), log_out[b + i], ins[i]);
        end

        // Randomized traffic, with one overrun partway through.
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(4, 7)), (i == 30));
        end
        repeat (4) @(negedge clk);
        chk("overrun_sticky", overrun, 1);

        // Reset while a sample is in its MAC cycle.
        @(negedge clk);
        in_data   = DW'(777);
        delay_num = AW'(1);
        bypass    = 1'b0;
        in_valid  = 1'b1;
        model_push(777, 1, 0, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        clear_model();
        check_zero_outputs("midop_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 65535)) - 32768, 15, 128, 255, 1'b0, 4, 1'b0);

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_delay_line.md
# echo_delay_line

Parametrised mono audio echo engine with an internal circular sample buffer, runtime-programmable delay, feedback (multi-repeat echo) and wet/dry mix. It sits in the audio path between the codec receive interface and the codec transmit interface, and is driven by a one-cycle sample strobe at audio rate. It supersedes the fixed single-repeat, FIFO-based delay: it adds feedback, mixing, fill tracking, bypass and overrun reporting.

## Interface
Parameters:
- DATA_W, 16, sample width (signed two's complement)
- ADDR_W, 13, buffer address width; DEPTH = 2^ADDR_W samples
- GAIN_W, 8, gain width; unsigned fraction, value/2^GAIN_W

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle sample strobe
- in_data  in  DATA_W  signed input sample
- delay_num  in  ADDR_W  echo delay in samples; sampled on accepted in_valid
- fb_gain  in  GAIN_W  feedback gain
- mix_gain  in  GAIN_W  wet gain applied to the delayed sample
- bypass  in  1  1 = out_data equals in_data; buffer still written with dry in_data
- out_valid  out  1  one-cycle result strobe
- out_data  out  DATA_W  signed output sample
- busy  out  1  high while a sample is in flight
- overrun  out  1  sticky; set when in_valid is dropped; cleared only by reset

## Operation
- FSM states:
  - IDLE: accepts in_valid, latches in_data, delay_num and both gains, and computes the read address rd = wr_ptr − delay_num (mod DEPTH). Goes to READ.
  - READ: presents rd to the RAM. Goes to MAC.
  - MAC: RAM data is valid; computes and registers the results. Goes to WRITE.
  - WRITE: writes the feedback value at wr_ptr, increments wr_ptr (wraps DEPTH−1 → 0), pulses out_valid. Goes to IDLE.
- Delayed sample d:
  - d = RAM[rd] if delay_num ≠ 0 and fill ≥ delay_num.
  - d = 0 otherwise. This covers uninitialised RAM after reset and a delay increased beyond the fill count.
- Fill counter fill:
  - Saturates at DEPTH−1.
  - Increments on each WRITE.
  - Not reset by delay changes.
- Arithmetic:
  - Each product is DATA_W signed × GAIN_W unsigned, then arithmetic right shift by GAIN_W (truncate toward −∞).
  - wet = in + (d·mix_gain >> GAIN_W).
  - fbv = in + (d·fb_gain >> GAIN_W).
  - Sums are computed at DATA_W+1 bits, then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Outputs:
  - out_data = bypass ? in : wet.
  - RAM write data = bypass ? in : fbv.
- Each accepted sample reads before it writes. delay_num = DEPTH−1 is the maximum echo length.
- in_valid in any state other than IDLE: the sample is dropped, overrun is set, and the in-flight sample is unaffected.
- Gain and delay changes take effect on the next accepted sample. No glitch-free crossfade is provided.

## Timing
- in_valid accepted at cycle T → busy high T+1..T+3 → out_valid and out_data registered at T+3 (latency 3).
- Minimum in_valid spacing is 4 cycles. At 48 kHz on a system clock ≥ 200 kHz this is always met.
- RAM: synchronous read with 1-cycle latency; synchronous write. Write and read never target the same cycle.
- out_data holds its value between out_valid pulses.
- Reset values: out_valid 0, out_data 0, busy 0, overrun 0, wr_ptr 0, fill 0, FSM IDLE. RAM contents are not cleared; the fill gating covers this.
- Reset mid-operation: the in-flight sample is abandoned, no out_valid is produced, and no RAM write occurs after reset assertion.

## Structure
- Package echo_pkg:
  - FSM state encoding (IDLE, READ, MAC, WRITE).
  - Default parameter constants.
  - Saturating-add function sat_add(a, b) and gain-multiply function gain_mul(d, g), shared with future mixer blocks.
- Sub-module echo_ram: simple dual-port DEPTH × DATA_W, 1-cycle registered read, inferable as block RAM. Ports: clk, we, waddr, wdata, raddr, rdata.
- Top level: FSM, pointer and fill logic, MAC datapath, output registers.

## Test plan
- Impulse: delay_num=4, fb_gain=0, mix_gain=255 (GAIN_W=8).
  - Stimulus: in_data 1000 then zeros, in_valid every 8 cycles.
  - Response: out_data 1000 at sample 0, 996 at sample 4, 0 elsewhere.
  - Each out_valid exactly 3 cycles after its in_valid.
- Feedback decay: delay_num=2, fb_gain=128, mix_gain=255.
  - Stimulus: impulse 1024.
  - Response: the feedback write value halves on each repeat (1024, 512, 256, …); out_data decays accordingly.
- Saturation: delay_num=1, mix_gain=255, fb_gain=255.
  - Stimulus: constant 30000.
  - Response: out_data clamps at 32767 and never wraps negative. Repeat with −30000 → clamps at −32768.
- Startup / fill gating, delay_num=100:
  - Samples 0–99 → out_data equals in_data (d=0).
  - Delay changed to 200 at sample 150 → d=0 until fill ≥ 200.
  - delay_num=0 → output dry.
- Overrun:
  - in_valid at T and T+2 → the second sample is dropped, overrun=1 at T+3, exactly one out_valid.
  - Overrun stays set until reset.
- Reset and wrap (ADDR_W=4):
  - reset_n low at T+2 of a sample → no out_valid; all outputs 0.
  - Then run 40 samples with delay_num=15 → correct echo across the wr_ptr wrap.
  - bypass=1 → out_data equals in_data exactly.
